// File: rtl/alu_multi.sv
// Multi-accumulator ALU with carry/zero flags, sticky ERROR state and an optional
// iterative shift-add multiplier, compiled in when ALU_MULTI_MUL_EN is defined.
module alu_multi #(
    parameter int WIDTH    = 8,
    parameter int ACCSEL_W = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [3+ACCSEL_W+WIDTH:0]     inst,
    input  logic                          inst_en,
    output logic                          inst_ready,
    output logic [WIDTH-1:0]              result,
    output logic                          flag_zero,
    output logic                          flag_carry,
    output logic                          error,
    output logic [1:0]                    dbg_state_o
);
    localparam int NACC = 2 ** ACCSEL_W;

    localparam logic [1:0] ST_READY = 2'd0;
    localparam logic [1:0] ST_ERROR = 2'd2;
`ifdef ALU_MULTI_MUL_EN
    localparam logic [1:0] ST_MUL   = 2'd1;
    localparam int         CNT_W    = $clog2(WIDTH + 1);
`endif

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_NOT = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_IOR = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
`ifdef ALU_MULTI_MUL_EN
    localparam logic [3:0] OP_MUL = 4'hA;
`endif

    logic [WIDTH-1:0]    acc_q [NACC];
    logic [WIDTH-1:0]    result_q, result_d;
    logic                zero_q, zero_d;
    logic                carry_q, carry_d;
    logic [1:0]          state_q, state_d;

    logic [3:0]          op;
    logic [ACCSEL_W-1:0] sel;
    logic [WIDTH-1:0]    imm;
    logic [WIDTH-1:0]    a_val;
    logic [WIDTH:0]      sum, diff;

    logic                wr_en;
    logic [ACCSEL_W-1:0] wr_sel;
    logic [WIDTH-1:0]    wr_data;

`ifdef ALU_MULTI_MUL_EN
    logic [2*WIDTH-1:0]  mcand_q, mcand_d;
    logic [2*WIDTH-1:0]  prod_q, prod_d, prod_n;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACCSEL_W-1:0] mul_sel_q, mul_sel_d;
`endif

    assign op    = inst[WIDTH+ACCSEL_W +: 4];
    assign sel   = inst[WIDTH +: ACCSEL_W];
    assign imm   = inst[WIDTH-1:0];
    assign a_val = acc_q[sel];
    assign sum   = {1'b0, a_val} + {1'b0, imm};
    // MSB of the widened difference is the borrow out.
    assign diff  = {1'b0, a_val} - {1'b0, imm};

    always_comb begin
        state_d  = state_q;
        carry_d  = carry_q;
        wr_en    = 1'b0;
        wr_sel   = sel;
        wr_data  = a_val;
`ifdef ALU_MULTI_MUL_EN
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        prod_n    = prod_q + (mplier_q[0] ? mcand_q : '0);
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        mul_sel_d = mul_sel_q;
`endif
        case (state_q)
            ST_READY: begin
                if (inst_en) begin
                    case (op)
                        OP_NOP: ;
                        OP_LDI: begin wr_en = 1'b1; wr_data = imm; end
                        OP_ADD: begin wr_en = 1'b1; wr_data = sum[WIDTH-1:0]; carry_d = sum[WIDTH]; end
                        OP_SUB: begin wr_en = 1'b1; wr_data = diff[WIDTH-1:0]; carry_d = diff[WIDTH]; end
                        OP_NOT: begin wr_en = 1'b1; wr_data = ~a_val; end
                        OP_AND: begin wr_en = 1'b1; wr_data = a_val & imm; end
                        OP_IOR: begin wr_en = 1'b1; wr_data = a_val | imm; end
                        OP_XOR: begin wr_en = 1'b1; wr_data = a_val ^ imm; end
                        OP_SHL: begin wr_en = 1'b1; wr_data = a_val << imm; end
                        OP_SHR: begin wr_en = 1'b1; wr_data = a_val >> imm; end
`ifdef ALU_MULTI_MUL_EN
                        OP_MUL: begin
                            state_d   = ST_MUL;
                            mcand_d   = {{WIDTH{1'b0}}, a_val};
                            mplier_d  = imm;
                            prod_d    = '0;
                            cnt_d     = CNT_W'(WIDTH);
                            mul_sel_d = sel;
                        end
`endif
                        default: state_d = ST_ERROR;
                    endcase
                end
            end
`ifdef ALU_MULTI_MUL_EN
            ST_MUL: begin
                prod_d   = prod_n;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_READY;
                    wr_en   = 1'b1;
                    wr_sel  = mul_sel_q;
                    wr_data = prod_n[WIDTH-1:0];
                    carry_d = |prod_n[2*WIDTH-1:WIDTH];
                end
            end
`endif
            default: ;
        endcase
        result_d = wr_en ? wr_data : result_q;
        zero_d   = wr_en ? (wr_data == '0) : zero_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            state_q  <= ST_READY;
        end else begin
            if (wr_en) acc_q[wr_sel] <= wr_data;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            state_q  <= state_d;
        end
    end

`ifdef ALU_MULTI_MUL_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_q   <= '0;
            prod_q    <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            mul_sel_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            mul_sel_q <= mul_sel_d;
        end
    end
`endif

    assign inst_ready  = (state_q == ST_READY);
    assign error       = (state_q == ST_ERROR);
    assign result      = result_q;
    assign flag_zero   = zero_q;
    assign flag_carry  = carry_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_alu_multi.sv
// Directed bench for alu_multi (default parameters); MUL checks run when
// ALU_MULTI_MUL_EN is defined, otherwise opcode A is checked as illegal.
module tb_alu_multi;
    logic        clock = 1'b0;
    logic        reset;
    logic [13:0] inst;
    logic        inst_en;
    logic        inst_ready;
    logic [7:0]  result;
    logic        flag_zero;
    logic        flag_carry;
    logic        error;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cycles;

    alu_multi #(.WIDTH(8), .ACCSEL_W(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .inst       (inst),
        .inst_en    (inst_en),
        .inst_ready (inst_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .error      (error),
        .dbg_state_o(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] sel, input logic [7:0] imm);
        @(negedge clock);
        inst    = {op, sel, imm};
        inst_en = 1'b1;
        @(posedge clock);
        #1;
        inst_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #12;
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (inst_ready !== 1'b1 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] r, input logic z, input logic c);
        chk({tag, ".result"}, 32'(result), 32'(r));
        chk({tag, ".zero"}, 32'(flag_zero), 32'(z));
        chk({tag, ".carry"}, 32'(flag_carry), 32'(c));
    endtask

    initial begin
        reset   = 1'b1;
        inst    = '0;
        inst_en = 1'b0;
        #12;
        reset = 1'b0;
        #1;
        chk_out("reset", 8'h00, 1'b0, 1'b0);
        chk("reset.error", 32'(error), 32'd0);
        chk("reset.ready", 32'(inst_ready), 32'd1);
        chk("reset.state", 32'(dbg_state), 32'd0);

        issue(4'h1, 2'd0, 8'h1A); chk_out("ldi0", 8'h1A, 1'b0, 1'b0);
        issue(4'h2, 2'd0, 8'h01); chk_out("add0", 8'h1B, 1'b0, 1'b0);
        issue(4'h3, 2'd0, 8'h02); chk_out("sub0", 8'h19, 1'b0, 1'b0);

        issue(4'h1, 2'd1, 8'hFF); chk_out("ldi1", 8'hFF, 1'b0, 1'b0);
        issue(4'h2, 2'd1, 8'h01); chk_out("add1_wrap", 8'h00, 1'b1, 1'b1);
        issue(4'h3, 2'd2, 8'h01); chk_out("sub2_borrow", 8'hFF, 1'b0, 1'b1);
        issue(4'h1, 2'd0, 8'h00); chk_out("ldi0_zero", 8'h00, 1'b1, 1'b1);
        issue(4'h4, 2'd1, 8'hxx); chk_out("not1", 8'hFF, 1'b0, 1'b1);
        issue(4'h0, 2'd2, 8'hxx); chk_out("nop", 8'hFF, 1'b0, 1'b1);

        issue(4'h1, 2'd2, 8'hF0); chk_out("ldi2", 8'hF0, 1'b0, 1'b1);
        issue(4'h5, 2'd2, 8'h3C); chk_out("and2", 8'h30, 1'b0, 1'b1);
        issue(4'h6, 2'd2, 8'h0F); chk_out("ior2", 8'h3F, 1'b0, 1'b1);
        issue(4'h7, 2'd2, 8'hFF); chk_out("xor2", 8'hC0, 1'b0, 1'b1);

        issue(4'h1, 2'd0, 8'h81); chk_out("ldi81", 8'h81, 1'b0, 1'b1);
        issue(4'h8, 2'd0, 8'h01); chk_out("shl1", 8'h02, 1'b0, 1'b1);
        issue(4'h9, 2'd0, 8'h09); chk_out("shr9", 8'h00, 1'b1, 1'b1);
        issue(4'h1, 2'd0, 8'hC0); chk_out("ldiC0", 8'hC0, 1'b0, 1'b1);
        issue(4'h9, 2'd0, 8'h03); chk_out("shr3", 8'h18, 1'b0, 1'b1);
        issue(4'h8, 2'd0, 8'h08); chk_out("shl8", 8'h00, 1'b1, 1'b1);

`ifdef ALU_MULTI_MUL_EN
        issue(4'h1, 2'd3, 8'h0C); chk_out("ldi3", 8'h0C, 1'b0, 1'b1);
        issue(4'hA, 2'd3, 8'h15);
        chk("mul.ready_low", 32'(inst_ready), 32'd0);
        chk("mul.state", 32'(dbg_state), 32'd1);
        // Hold an ADD on the bus while busy; it must be ignored.
        inst    = {4'h2, 2'd3, 8'h01};
        inst_en = 1'b1;
        cycles  = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (inst_ready === 1'b1) break;
            cycles++;
        end
        inst_en = 1'b0;
        chk("mul.busy_cycles", 32'(cycles), 32'd8);
        chk_out("mul_fc", 8'hFC, 1'b0, 1'b0);

        issue(4'hA, 2'd3, 8'h02);
        wait_ready(cycles);
        chk("mul2.cycles", 32'(cycles), 32'd8);
        chk_out("mul_f8", 8'hF8, 1'b0, 1'b1);

        issue(4'h1, 2'd3, 8'h05); chk_out("ldi3_5", 8'h05, 1'b0, 1'b1);
        issue(4'hA, 2'd3, 8'h03);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("midmul.ready", 32'(inst_ready), 32'd1);
        chk_out("midmul", 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        issue(4'h6, 2'd3, 8'h00); chk_out("midmul_acc3", 8'h00, 1'b1, 1'b0);
`else
        issue(4'hA, 2'd3, 8'h02);
        chk("opA.error", 32'(error), 32'd1);
        chk("opA.ready", 32'(inst_ready), 32'd0);
        chk_out("opA_hold", 8'h00, 1'b1, 1'b1);
        do_reset();
        chk("opA.reset_error", 32'(error), 32'd0);
`endif

        issue(4'h1, 2'd1, 8'h37); chk_out("pre_err", 8'h37, 1'b0, 1'b0);
        issue(4'hF, 2'd1, 8'h00);
        chk("err.error", 32'(error), 32'd1);
        chk("err.ready", 32'(inst_ready), 32'd0);
        chk("err.state", 32'(dbg_state), 32'd2);
        issue(4'h2, 2'd1, 8'h01);
        issue(4'h1, 2'd1, 8'h99);
        chk_out("err_hold", 8'h37, 1'b0, 1'b0);
        chk("err.sticky", 32'(error), 32'd1);
        do_reset();
        chk("err.reset_error", 32'(error), 32'd0);
        chk("err.reset_ready", 32'(inst_ready), 32'd1);
        chk_out("err_reset", 8'h00, 1'b0, 1'b0);
        issue(4'h1, 2'd0, 8'hAA); chk_out("ldiAA", 8'hAA, 1'b0, 1'b0);
        issue(4'h4, 2'd1, 8'hxx); chk_out("not1_after_reset", 8'hFF, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
